// File: rtl/micpu_pkg.sv
// Shared miCPU definitions: default bus widths, reset vector and the
// fetch-queue entry layout used between the fetch stage and decode.
package micpu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC  = '0;
  localparam logic [DATA_W-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue for the fetch stage: synchronous FIFO of {pc, instr}
// entries with a flush that wins over push and pop.
module fetch_fifo
  import micpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           din,
  output entry_t           dout,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign dout   = mem[rptr];

  // NOTE: the storage array is deliberately not reset; count alone decides
  // which slots hold live data, so clearing the RAM would only cost area.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= din;
  end

  // NOTE: sequential state is always written with <=, so every flop sees the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// miCPU instruction fetch: owns the PC, issues reads to a 1-cycle sync
// instruction memory under a credit limit, and queues results for decode.
module fetch_stage #(
  parameter int                ADDR_W   = micpu_pkg::ADDR_W,
  parameter int                DATA_W   = micpu_pkg::DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(micpu_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CRD_W = $clog2(DEPTH + 2);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic [CNT_W-1:0]  occ;
  logic [CRD_W-1:0]  credit;
  logic              pop;
  logic              push;
  logic              issue;
  entry_t            head;
  entry_t            tail;
  logic              unused_br_lsbs;

  // NOTE: every always_comb output gets a value on every path (here by plain
  // assignment at the top) so no latch can be inferred.
  always_comb begin
    if_valid = (occ != '0);
    pop      = if_valid && if_ready;
    // Slots already spoken for: queued entries plus the read still in flight,
    // minus the head leaving this cycle.
    credit   = CRD_W'(occ) + CRD_W'(inflight) - CRD_W'(pop);
    issue    = !br_taken && (credit < CRD_W'(DEPTH));
    push     = inflight && !br_taken;
    tail     = '{pc: req_pc, instr: imem_rdata};
  end

  assign imem_en        = issue && rst;
  assign imem_addr      = pc;
  assign if_instr       = if_valid ? head.instr : '0;
  assign if_pc          = if_valid ? head.pc    : '0;
  assign unused_br_lsbs = ^br_target[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (br_taken) begin
        pc <= {br_target[ADDR_W-1:2], 2'b00};
      end else if (issue) begin
        pc     <= pc + ADDR_W'(4);
        req_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(br_taken),
    .din  (tail),
    .dout (head),
    .count(occ)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table for free-run and
// redirect, plus hand-written backpressure, flush, wrap and reset sequences.
module tb_fetch_stage;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          br_taken  = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic          if_valid;
  logic          if_ready  = 1'b0;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;

  int            tests = 0;
  int            fails = 0;
  logic [31:0]   got[$];
  logic [31:0]   addrs[$];
  logic          overflow_seen = 1'b0;

  typedef struct {
    logic        ready;
    logic        br;
    logic [31:0] target;
    logic        en;
    logic        chk_addr;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[11];

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .br_taken  (br_taken),
    .br_target (br_target),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  // 1-cycle synchronous instruction memory model
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_fn(imem_addr);
  end

  // A push into a full queue without a matching pop would be an overflow.
  always @(negedge clk) begin
    if (rst && dut.push && !dut.pop && (int'(dut.occ) == DEPTH)) overflow_seen = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic ready, input logic br, input logic [31:0] target,
                              input logic en, input logic chk_addr, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
    vec_t v;
    v.ready = ready; v.br = br; v.target = target; v.en = en;
    v.chk_addr = chk_addr; v.addr = addr; v.valid = valid; v.pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset, checks reset outputs, releases at the start of cycle 0.
  task automatic apply_reset();
    rst       = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    if_ready  = 1'b1;
    tick();
    @(negedge clk);
    check("rst_en",    32'(imem_en),  32'h0);
    check("rst_addr",  imem_addr,     32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", if_instr,      32'h0);
    check("rst_pc",    if_pc,         32'h0);
    tick();
    rst = 1'b1;
  endtask

  // Runs n cycles with the given ready, recording delivered PCs.
  task automatic collect(input int n, input logic ready);
    for (int c = 0; c < n; c++) begin
      if_ready = ready;
      @(negedge clk);
      if (if_valid && if_ready) begin
        got.push_back(if_pc);
        check("deliv_instr", if_instr, mem_fn(if_pc));
      end
      tick();
    end
  endtask

  initial begin
    int en_cnt;

    // cycle-indexed from reset release: free-run, then redirect to 0x103 in cycle 6
    tv[0]  = mk(1, 0, 32'h0,   1, 1, 32'h000, 0, 32'h000);
    tv[1]  = mk(1, 0, 32'h0,   1, 1, 32'h004, 0, 32'h000);
    tv[2]  = mk(1, 0, 32'h0,   1, 1, 32'h008, 1, 32'h000);
    tv[3]  = mk(1, 0, 32'h0,   1, 1, 32'h00C, 1, 32'h004);
    tv[4]  = mk(1, 0, 32'h0,   1, 1, 32'h010, 1, 32'h008);
    tv[5]  = mk(1, 0, 32'h0,   1, 1, 32'h014, 1, 32'h00C);
    tv[6]  = mk(1, 1, 32'h103, 0, 0, 32'h000, 1, 32'h010);
    tv[7]  = mk(1, 0, 32'h0,   1, 1, 32'h100, 0, 32'h000);
    tv[8]  = mk(1, 0, 32'h0,   1, 1, 32'h104, 0, 32'h000);
    tv[9]  = mk(1, 0, 32'h0,   1, 1, 32'h108, 1, 32'h100);
    tv[10] = mk(1, 0, 32'h0,   1, 1, 32'h10C, 1, 32'h104);

    apply_reset();
    for (int i = 0; i < 11; i++) begin
      if_ready  = tv[i].ready;
      br_taken  = tv[i].br;
      br_target = tv[i].target;
      @(negedge clk);
      check($sformatf("tv%0d_en", i), 32'(imem_en), 32'(tv[i].en));
      if (tv[i].chk_addr) check($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
      check($sformatf("tv%0d_valid", i), 32'(if_valid), 32'(tv[i].valid));
      if (tv[i].valid) begin
        check($sformatf("tv%0d_pc", i), if_pc, tv[i].pc);
        check($sformatf("tv%0d_instr", i), if_instr, mem_fn(tv[i].pc));
      end
      tick();
    end
    br_taken = 1'b0;

    // Backpressure from cycle 0: exactly DEPTH fetches, head held stable.
    apply_reset();
    en_cnt = 0;
    addrs.delete();
    for (int c = 0; c < 10; c++) begin
      if_ready = 1'b0;
      @(negedge clk);
      if (imem_en) begin
        en_cnt++;
        addrs.push_back(imem_addr);
      end
      if (c >= 2) begin
        check("bp_valid", 32'(if_valid), 32'h1);
        check("bp_pc",    if_pc,         32'h0);
        check("bp_instr", if_instr,      mem_fn(32'h0));
      end
      tick();
    end
    check("bp_en_count", 32'(en_cnt), 32'(DEPTH));
    for (int k = 0; k < addrs.size(); k++) check("bp_addr", addrs[k], 32'(k * 4));
    got.delete();
    if_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_en",   32'(imem_en), 32'h1);
    check("bp_resume_addr", imem_addr,    32'h10);
    if (if_valid) got.push_back(if_pc);
    tick();
    collect(11, 1'b1);
    check("bp_deliv_count", 32'(got.size()), 32'd12);
    for (int k = 0; k < got.size(); k++) check("bp_deliv_pc", got[k], 32'(k * 4));

    // Redirect while the queue is full and decode pops the head.
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      if_ready = 1'b0;
      tick();
    end
    if_ready  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h200;
    @(negedge clk);
    check("fl_head_pc", if_pc,         32'h0);
    check("fl_en",      32'(imem_en),  32'h0);
    tick();
    br_taken = 1'b0;
    @(negedge clk);
    check("fl_empty",   32'(if_valid), 32'h0);
    check("fl_en_next", 32'(imem_en),  32'h1);
    check("fl_addr",    imem_addr,     32'h200);
    tick();
    got.delete();
    collect(6, 1'b1);
    check("fl_deliv_count", 32'(got.size()), 32'd5);
    for (int k = 0; k < got.size(); k++) check("fl_deliv_pc", got[k], 32'h200 + 32'(k * 4));

    // PC wrap at the top of the address space.
    if_ready  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    got.delete();
    collect(6, 1'b1);
    check("wrap_count", 32'(got.size()), 32'd4);
    if (got.size() >= 2) begin
      check("wrap_pc0", got[0], 32'hFFFF_FFFC);
      check("wrap_pc1", got[1], 32'h0000_0000);
    end

    // Asynchronous reset while a fetch is being issued.
    tick();
    check("mid_en_before", 32'(imem_en), 32'h1);
    rst = 1'b0;
    #1;
    check("mid_en",    32'(imem_en),  32'h0);
    check("mid_addr",  imem_addr,     32'h0);
    check("mid_valid", 32'(if_valid), 32'h0);
    check("mid_instr", if_instr,      32'h0);
    check("mid_pc",    if_pc,         32'h0);
    tick();
    rst = 1'b1;
    got.delete();
    collect(6, 1'b1);
    check("mid_deliv_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < got.size(); k++) check("mid_deliv_pc", got[k], 32'(k * 4));

    check("no_overflow", 32'(overflow_seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the miCPU core. It sits directly upstream of the `part1` decode/execute datapath. The stage:

- owns the program counter;
- issues word-aligned reads to a 1-cycle-latency synchronous instruction memory;
- buffers returned words with their PC in a small prefetch FIFO;
- hands them to decode over a valid/ready handshake.

Taken branches redirect the PC, flush the FIFO and discard any in-flight fetch.

## Interface
- `ADDR_W`, 32: PC and memory address width.
- `DATA_W`, 32: instruction width.
- `DEPTH`, 4: prefetch FIFO entries; power of two, minimum 2.
- `RESET_PC`, 0: first fetch address; low 2 bits must be 0.

- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset; deassertion is synchronous to `clk` upstream.
- `imem_en`  out  1: read strobe to instruction memory.
- `imem_addr`  out  `ADDR_W`: read address, always word-aligned.
- `imem_rdata`  in  `DATA_W`: read data, valid in the cycle after `imem_en`.
- `br_taken`  in  1: redirect request from execute, single-cycle pulse.
- `br_target`  in  `ADDR_W`: redirect address; bits [1:0] ignored (forced 0).
- `if_valid`  out  1: FIFO head holds a valid instruction.
- `if_ready`  in  1: decode accepts the head this cycle.
- `if_instr`  out  `DATA_W`: head instruction.
- `if_pc`  out  `ADDR_W`: PC of head instruction.

## Operation
- **Reset.** While `rst`=0:
  - `pc`=`RESET_PC`; FIFO empty; in-flight flag 0.
  - Outputs: `imem_en`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0.
- **Issue rule.** `imem_en`=1 when `occupancy + inflight − pop < DEPTH` and no redirect is being taken this cycle.
  - `pop` = `if_valid & if_ready`.
  - On issue: `imem_addr`=`pc`, then `pc` += 4, and `inflight` is set for the next cycle.
  - `imem_en` and `imem_addr` are combinational from registered state.
- **Response.** In the cycle after an issue, {`pc_of_request`, `imem_rdata`} is written to the FIFO tail, unless that cycle carries `br_taken`.
- **Handshake.**
  - Head is popped on `if_valid & if_ready`.
  - `if_instr`/`if_pc` must hold stable while `if_valid`=1 and `if_ready`=0.
- **Redirect (`br_taken`=1 in cycle N):**
  - `imem_en`=0 in N.
  - The response arriving in N is dropped.
  - FIFO cleared at end of N, overriding any push or pop.
  - `pc` ← {`br_target`[ADDR_W-1:2], 2'b00}.
  - A pop handshake coincident with `br_taken` counts as consumed by decode; the FIFO is still cleared.
- **PC arithmetic.** `pc` wraps modulo 2^ADDR_W with no error.
- **FIFO boundaries.**
  - Simultaneous push and pop when full or empty is legal; occupancy is unchanged (full) or the pushed entry becomes head next cycle (empty).
  - Overflow is impossible by the issue rule. The bench asserts this.
- **Reset mid-operation.** Asynchronous clear of all state. A response returning after reset deassertion is ignored, because the in-flight flag was cleared.

## Timing
- After `rst` deasserts, cycle 0:
  - `imem_en`=1, `imem_addr`=`RESET_PC`.
  - Data arrives in cycle 1.
  - `if_valid`=1 with `if_pc`=`RESET_PC` in cycle 2.
- **Fetch-to-decode latency:** 2 cycles.
- **Steady-state throughput:** 1 instruction/cycle with `if_ready` held high.
- **Redirect latency:**
  - `br_taken` in N → first fetch of target in N+1 → `if_valid` with `if_pc`=target in N+3.
  - `if_valid`=0 in N+1 and N+2.
- **Backpressure:** with `if_ready`=0, issue stops once `occupancy + inflight` = `DEPTH`. The FIFO then holds exactly `DEPTH` entries.

## Structure
- Shared package `micpu_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults and `RESET_PC`;
  - `INSTR_NOP` constant;
  - packed struct `fetch_entry_t` {pc, instr}.
- One sub-module, `fetch_fifo`:
  - synchronous FIFO of `fetch_entry_t`;
  - ports: push, pop, flush, occupancy count;
  - flush has priority over push/pop.
- The top of `fetch_stage` holds the PC, issue/credit logic and in-flight/kill tracking.

## Test plan
- **Reset then free-run:** `RESET_PC`=0, `if_ready`=1 → `if_pc` sequence 0x0, 0x4, 0x8… one per cycle starting cycle 2; `if_instr` matches the memory model.
- **Backpressure:** `if_ready`=0 from cycle 0 → exactly 4 `imem_en` pulses (0x0–0xC). `if_instr`/`if_pc` stay stable. Raising `if_ready` → 0x10 fetched next cycle, with no gap in delivered PCs.
- **Redirect:** `br_taken` with `br_target`=0x103 in cycle 6:
  - `imem_en`=0 in cycle 6;
  - `imem_addr`=0x100 in cycle 7;
  - `if_valid` low in cycles 7–8;
  - `if_pc`=0x100 in cycle 9;
  - no stale PC delivered.
- **Redirect with FIFO full and simultaneous pop** → FIFO empty next cycle; only target-path PCs appear afterwards.
- **Wrap:** `br_target`=0xFFFF_FFFC → delivered PCs 0xFFFF_FFFC, 0x0000_0000.
- **Reset mid-stream:** assert `rst`=0 while `imem_en`=1 → all outputs return to reset values immediately. After release, the first delivered `if_pc`=`RESET_PC`.
